// File: rtl/game_pkg.sv
// Shared types and character constants for the game record serialiser.
package game_pkg;

  typedef enum logic [3:0] {
    IDLE, HDR, ID, COLON, NUM, SPACE, COLOR, SEP, DSEP, WAIT_DRAW, NL
  } state_t;

  typedef enum logic [1:0] {RED, GREEN, BLUE} colour_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_SEMI  = 8'h3B;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // Characters of the "Game " header by position.
  function automatic logic [7:0] hdr_char(input logic [2:0] pos);
    case (pos)
      3'd0:    return 8'h47;  // G
      3'd1:    return 8'h61;  // a
      3'd2:    return 8'h6D;  // m
      3'd3:    return 8'h65;  // e
      default: return ASCII_SPACE;
    endcase
  endfunction

  // Number of characters in a colour name.
  function automatic logic [2:0] colour_len(input colour_t c);
    case (c)
      RED:     return 3'd3;
      GREEN:   return 3'd5;
      default: return 3'd4;
    endcase
  endfunction

  // Character of a colour name by position.
  function automatic logic [7:0] colour_char(input colour_t c, input logic [2:0] pos);
    case (c)
      RED: begin
        case (pos)
          3'd0:    return 8'h72;  // r
          3'd1:    return 8'h65;  // e
          default: return 8'h64;  // d
        endcase
      end
      GREEN: begin
        case (pos)
          3'd0:      return 8'h67;  // g
          3'd1:      return 8'h72;  // r
          3'd2, 3'd3: return 8'h65; // e
          default:   return 8'h6E;  // n
        endcase
      end
      default: begin
        case (pos)
          3'd0:    return 8'h62;  // b
          3'd1:    return 8'h6C;  // l
          3'd2:    return 8'h75;  // u
          default: return 8'h65;  // e
        endcase
      end
    endcase
  endfunction

endpackage

// File: rtl/u8_to_dec.sv
// 8-bit binary to three ASCII decimal digits plus significant digit count.
module u8_to_dec
  import game_pkg::*;
(
  input  logic [7:0] value_i,
  output logic [7:0] hund_o,
  output logic [7:0] tens_o,
  output logic [7:0] ones_o,
  output logic [1:0] ndig_o
);

  logic [7:0] h;
  logic [7:0] t;
  logic [7:0] o;

  // Constant-divisor split into digits; count drives leading-zero suppression.
  always_comb begin
    h      = value_i / 8'd100;
    t      = (value_i / 8'd10) % 8'd10;
    o      = value_i % 8'd10;
    hund_o = ASCII_ZERO + h;
    tens_o = ASCII_ZERO + t;
    ones_o = ASCII_ZERO + o;
    if (value_i >= 8'd100)     ndig_o = 2'd3;
    else if (value_i >= 8'd10) ndig_o = 2'd2;
    else                       ndig_o = 2'd1;
  end

endmodule

// File: rtl/game_record_tx.sv
// Serialises accepted draws into "Game <id>: <n> <colour>, ...; ...\n" text,
// one ASCII character per valid/ready handshake.
module game_record_tx
  import game_pkg::*;
#(
  parameter logic [7:0] FIRST_ID = 8'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       draw_valid,
  output logic       draw_ready,
  input  logic [7:0] draw_red,
  input  logic [7:0] draw_green,
  input  logic [7:0] draw_blue,
  input  logic       draw_last,
  output logic [7:0] char_out,
  output logic       output_valid,
  input  logic       char_ready,
  output logic [7:0] game_id
);

  state_t     state_q, state_d;
  colour_t    colour_q, colour_d, in_first, next_colour;
  logic [7:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [7:0] game_id_q, game_id_d;
  logic [2:0] pos_q, pos_d;
  logic       last_q, last_d;
  logic       ready_en_q, ready_en_d;

  logic [7:0] cur_count, dec_in, dig_h, dig_t, dig_o, digit;
  logic [1:0] ndig, didx;
  logic       accept, adv, last_digit, has_next;

  assign accept  = draw_valid && draw_ready;
  assign adv     = output_valid && char_ready;
  assign game_id = game_id_q;

  // Count of the colour being emitted, or the game ID while in the ID field.
  always_comb begin
    case (colour_q)
      RED:     cur_count = red_q;
      GREEN:   cur_count = green_q;
      default: cur_count = blue_q;
    endcase
    dec_in = (state_q == ID) ? game_id_q : cur_count;
  end

  u8_to_dec u_dec (
    .value_i (dec_in),
    .hund_o  (dig_h),
    .tens_o  (dig_t),
    .ones_o  (dig_o),
    .ndig_o  (ndig)
  );

  // Digit position skips leading zeros; colour selection skips zero counts.
  always_comb begin
    didx       = 2'(2'd3 - ndig + pos_q[1:0]);
    last_digit = (pos_q[1:0] == 2'(ndig - 2'd1));
    case (didx)
      2'd0:    digit = dig_h;
      2'd1:    digit = dig_t;
      default: digit = dig_o;
    endcase
    // An all-zero draw still prints "0 red".
    if (draw_red != 8'd0 || (draw_green == 8'd0 && draw_blue == 8'd0)) in_first = RED;
    else if (draw_green != 8'd0)                                         in_first = GREEN;
    else                                                                 in_first = BLUE;
    has_next    = 1'b0;
    next_colour = BLUE;
    if (colour_q == RED && green_q != 8'd0) begin
      has_next    = 1'b1;
      next_colour = GREEN;
    end else if (colour_q != BLUE && blue_q != 8'd0) begin
      has_next    = 1'b1;
      next_colour = BLUE;
    end
  end

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      colour_q   <= RED;
      red_q      <= 8'd0;
      green_q    <= 8'd0;
      blue_q     <= 8'd0;
      last_q     <= 1'b0;
      pos_q      <= 3'd0;
      game_id_q  <= FIRST_ID;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      colour_q   <= colour_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      last_q     <= last_d;
      pos_q      <= pos_d;
      game_id_q  <= game_id_d;
      ready_en_q <= ready_en_d;
    end
  end

  // Next state: each field advances only on a character handshake.
  always_comb begin
    state_d    = state_q;
    colour_d   = colour_q;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    last_d     = last_q;
    pos_d      = pos_q;
    game_id_d  = game_id_q;
    ready_en_d = 1'b1;
    if ((state_q == IDLE || state_q == WAIT_DRAW) && accept) begin
      state_d  = (state_q == IDLE) ? HDR : NUM;
      pos_d    = 3'd0;
      red_d    = draw_red;
      green_d  = draw_green;
      blue_d   = draw_blue;
      last_d   = draw_last;
      colour_d = in_first;
    end else if (adv) begin
      pos_d = pos_q + 3'd1;
      case (state_q)
        HDR:   if (pos_q == 3'd4) begin state_d = ID;    pos_d = 3'd0; end
        ID:    if (last_digit)    begin state_d = COLON; pos_d = 3'd0; end
        COLON: if (pos_q == 3'd1) begin state_d = NUM;   pos_d = 3'd0; end
        NUM:   if (last_digit)    begin state_d = SPACE; pos_d = 3'd0; end
        SPACE: begin state_d = COLOR; pos_d = 3'd0; end
        COLOR: begin
          if (pos_q == colour_len(colour_q) - 3'd1) begin
            pos_d = 3'd0;
            if (has_next) begin
              state_d  = SEP;
              colour_d = next_colour;
            end else if (last_q) begin
              state_d = NL;
            end else begin
              state_d = DSEP;
            end
          end
        end
        SEP:   if (pos_q == 3'd1) begin state_d = NUM;       pos_d = 3'd0; end
        DSEP:  if (pos_q == 3'd1) begin state_d = WAIT_DRAW; pos_d = 3'd0; end
        NL: begin
          state_d   = IDLE;
          pos_d     = 3'd0;
          game_id_d = game_id_q + 8'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: character and valid decoded from state and position.
  always_comb begin
    output_valid = 1'b1;
    char_out     = 8'd0;
    case (state_q)
      HDR:       char_out = hdr_char(pos_q);
      ID, NUM:   char_out = digit;
      COLON:     char_out = (pos_q == 3'd0) ? ASCII_COLON : ASCII_SPACE;
      SPACE:     char_out = ASCII_SPACE;
      COLOR:     char_out = colour_char(colour_q, pos_q);
      SEP:       char_out = (pos_q == 3'd0) ? ASCII_COMMA : ASCII_SPACE;
      DSEP:      char_out = (pos_q == 3'd0) ? ASCII_SEMI : ASCII_SPACE;
      NL:        char_out = ASCII_LF;
      default:   output_valid = 1'b0;
    endcase
    draw_ready = ready_en_q && !output_valid && (state_q == IDLE || state_q == WAIT_DRAW);
  end

endmodule

// File: doc/game_record_tx.md
GAME_RECORD_TX -- requirements
Module: game_record_tx

Interface
REQ-001 SHALL have parameter FIRST_ID, default 8'd1: game ID emitted for the first game after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port draw_valid  input  1  draw fields valid.
REQ-005 SHALL have port draw_ready  output  1  block accepts draw this cycle.
REQ-006 SHALL have ports draw_red, draw_green, draw_blue  input  8 each  unsigned cube counts.
REQ-007 SHALL have port draw_last  input  1  draw closes the current game.
REQ-008 SHALL have port char_out  output  8  ASCII character.
REQ-009 SHALL have port output_valid  output  1  char_out valid.
REQ-010 SHALL have port char_ready  input  1  downstream consumes char_out.
REQ-011 SHALL have port game_id  output  8  ID of the game being or next to be emitted.

Function
REQ-012 SHALL accept a draw only on draw_valid && draw_ready, registering all draw fields.
REQ-013 SHALL assert draw_ready only in states IDLE and WAIT_DRAW with output_valid low.
REQ-014 SHALL emit per game: "Game ", decimal game_id, ": ", draws joined by "; ", then LF (8'd10).
REQ-015 SHALL emit each draw as nonzero colours in order red, green, blue, each "<n> <colour>", joined by ", ".
REQ-016 SHALL emit "0 red" for a draw with all three counts zero.
REQ-017 SHALL format numbers 0..255 in decimal, 1-3 digits, no leading zeros.
REQ-018 SHALL hold char_out and output_valid stable until char_ready; advance one char per cycle with output_valid && char_ready.
REQ-019 SHALL present the first char of a draw's output the cycle after acceptance.
REQ-020 SHALL, after a draw with draw_last=0, emit "; " then enter WAIT_DRAW without header.
REQ-021 SHALL, after a draw with draw_last=1, emit LF, increment game_id mod 256 (255 -> 0) on the LF handshake, and enter IDLE.
REQ-022 SHALL sequence states IDLE -> HDR -> ID -> COLON -> NUM -> SPACE -> COLOR -> (SEP -> NUM | DSEP -> WAIT_DRAW -> NUM | NL -> IDLE).
REQ-023 SHALL ignore draw_valid outside IDLE/WAIT_DRAW; fields SHALL NOT be sampled then.
REQ-024 SHALL keep output_valid high continuously within a draw when char_ready is held high (no bubbles).

Reset
REQ-025 SHALL on rst_n low: state IDLE, output_valid 0, char_out 0, draw_ready 0 (goes 1 first clock after release), game_id FIRST_ID.
REQ-026 SHALL abandon any partial record on mid-operation reset; no further chars of it emitted.

Structure
REQ-027 SHALL place state enum, colour enum (RED, GREEN, BLUE) and ASCII constants (space, colon, comma, semicolon, LF, '0') in shared package game_pkg.
REQ-028 SHALL instantiate one sub-module u8_to_dec: 8-bit binary to three ASCII digits plus digit count.

Verification
REQ-029 SHALL cover: after reset, draw {4,0,3,last=1}, char_ready=1 -> "Game 1: 4 red, 3 blue\n", 22 consecutive valid cycles, game_id then 2.
REQ-030 SHALL cover: draws {0,2,0,0} then {1,1,1,1} -> "Game 1: 2 green; 1 red, 1 green, 1 blue\n".
REQ-031 SHALL cover: draw {255,10,0,1} -> "Game 1: 255 red, 10 green\n"; all-zero draw -> "Game 2: 0 red\n".
REQ-032 SHALL cover: char_ready toggled randomly -> identical char sequence, char_out stable while stalled.
REQ-033 SHALL cover: FIRST_ID=255, two single-draw games -> IDs "255" then "0".
REQ-034 SHALL cover: rst_n low after "Game " -> output_valid 0 asynchronously; next draw yields "Game 1: ...".
